// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce controller: FSM state encoding and glitch-counter limits.
package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t STABLE_LOW  = 2'b00;
    localparam state_t CHECK_HIGH  = 2'b01;
    localparam state_t STABLE_HIGH = 2'b10;
    localparam state_t CHECK_LOW   = 2'b11;

    localparam int GLITCH_W_DEFAULT = 8;
    localparam logic [GLITCH_W_DEFAULT-1:0] GLITCH_MAX = 8'hFF;

    // A qualification is in progress (Timer must be counting) only in the CHECK states.
    function automatic logic is_check(input state_t st);
        return (st == CHECK_HIGH) || (st == CHECK_LOW);
    endfunction

endpackage

// File: rtl/sync_2ff_chain.sv
// Multi-flop synchroniser for a single asynchronous level; reset loads the idle level.
module sync_2ff_chain #(
    parameter int   NUM_SYNC    = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic synced
);

    logic [NUM_SYNC-1:0] chain_r;

    // Shift the raw level through the flop chain.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain_r <= {NUM_SYNC{RESET_LEVEL}};
        end else begin
            chain_r <= {chain_r[NUM_SYNC-2:0], raw};
        end
    end

    assign synced = chain_r[NUM_SYNC-1];

endmodule

// File: rtl/debounce_ctrl.sv
// Debounce controller: qualifies each synchronised input change with an external Timer
// before committing it, and reports commits as pulses and aborted attempts as a glitch count.
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int   NUM_SYNC    = 2,
    parameter logic RESET_LEVEL = 1'b0,
    parameter int   GLITCH_W    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                noisy_in,
    input  logic                timer_DONE,
    output logic                timer_EN,
    output logic                debounced_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam state_t              RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
    localparam logic [GLITCH_W-1:0] GLITCH_SAT  = {GLITCH_W{1'b1}};

    logic                sync_in_s;
    state_t              state_r;
    state_t              next_state_s;
    logic                abort_s;
    logic                timer_en_r;
    logic                level_r;
    logic                rise_r;
    logic                fall_r;
    logic [GLITCH_W-1:0] glitch_r;
    logic                timer_en_nxt_s;
    logic                level_nxt_s;
    logic                rise_nxt_s;
    logic                fall_nxt_s;
    logic [GLITCH_W-1:0] glitch_nxt_s;

    sync_2ff_chain #(
        .NUM_SYNC    (NUM_SYNC),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .CLK    (CLK),
        .RST    (RST),
        .raw    (noisy_in),
        .synced (sync_in_s)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a revert of the input outranks timer_DONE, so a simultaneous DONE is an abort.
    always_comb begin
        next_state_s = state_r;
        abort_s      = 1'b0;
        case (state_r)
            STABLE_LOW: begin
                if (sync_in_s) next_state_s = CHECK_HIGH;
                else           next_state_s = STABLE_LOW;
            end
            CHECK_HIGH: begin
                if (!sync_in_s) begin
                    next_state_s = STABLE_LOW;
                    abort_s      = 1'b1;
                end else if (timer_DONE) begin
                    next_state_s = STABLE_HIGH;
                end else begin
                    next_state_s = CHECK_HIGH;
                end
            end
            STABLE_HIGH: begin
                if (!sync_in_s) next_state_s = CHECK_LOW;
                else            next_state_s = STABLE_HIGH;
            end
            CHECK_LOW: begin
                if (sync_in_s) begin
                    next_state_s = STABLE_HIGH;
                    abort_s      = 1'b1;
                end else if (timer_DONE) begin
                    next_state_s = STABLE_LOW;
                end else begin
                    next_state_s = CHECK_LOW;
                end
            end
            default: begin
                next_state_s = RESET_STATE;
                abort_s      = 1'b0;
            end
        endcase
    end

    // Output decode from the transition being taken, so every output is a registered copy.
    always_comb begin
        timer_en_nxt_s = is_check(next_state_s);
        level_nxt_s    = (next_state_s == STABLE_HIGH) || (next_state_s == CHECK_LOW);
        rise_nxt_s     = (state_r == CHECK_HIGH) && (next_state_s == STABLE_HIGH) && !abort_s;
        fall_nxt_s     = (state_r == CHECK_LOW)  && (next_state_s == STABLE_LOW)  && !abort_s;
        if (abort_s && (glitch_r != GLITCH_SAT)) begin
            glitch_nxt_s = glitch_r + GLITCH_W'(1);
        end else begin
            glitch_nxt_s = glitch_r;
        end
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timer_en_r <= 1'b0;
            level_r    <= RESET_LEVEL;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            glitch_r   <= {GLITCH_W{1'b0}};
        end else begin
            timer_en_r <= timer_en_nxt_s;
            level_r    <= level_nxt_s;
            rise_r     <= rise_nxt_s;
            fall_r     <= fall_nxt_s;
            glitch_r   <= glitch_nxt_s;
        end
    end

    assign timer_EN      = timer_en_r;
    assign debounced_out = level_r;
    assign rise_pulse    = rise_r;
    assign fall_pulse    = fall_r;
    assign glitch_cnt    = glitch_r;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Directed bench for debounce_ctrl with a Timer model, an abstract reference model checked every cycle,
// and hand-computed latency/count checks.
module tb_debounce_ctrl;

    localparam int NS = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       noisy_in = 1'b0;
    logic       timer_DONE, timer_DONE2;
    logic       timer_EN, debounced_out, rise_pulse, fall_pulse;
    logic [7:0] glitch_cnt;
    logic       timer_EN2, debounced_out2, rise_pulse2, fall_pulse2;
    logic [1:0] glitch_cnt2;

    int tests = 0;
    int fails = 0;
    int rise_n = 0;
    int fall_n = 0;
    int en_seen = 0;
    int tcnt, tcnt2;

    always #5 CLK = ~CLK;

    debounce_ctrl #(.NUM_SYNC(NS), .RESET_LEVEL(1'b0), .GLITCH_W(8)) dut (
        .CLK(CLK), .RST(RST), .noisy_in(noisy_in), .timer_DONE(timer_DONE),
        .timer_EN(timer_EN), .debounced_out(debounced_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .glitch_cnt(glitch_cnt));

    debounce_ctrl #(.NUM_SYNC(NS), .RESET_LEVEL(1'b0), .GLITCH_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .noisy_in(noisy_in), .timer_DONE(timer_DONE2),
        .timer_EN(timer_EN2), .debounced_out(debounced_out2), .rise_pulse(rise_pulse2),
        .fall_pulse(fall_pulse2), .glitch_cnt(glitch_cnt2));

    // Timer models, delay 100: DONE rises 101 cycles after EN rises, cleared while EN is low.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tcnt <= 0; timer_DONE <= 1'b0;
        end else if (!timer_EN) begin
            tcnt <= 0; timer_DONE <= 1'b0;
        end else if (tcnt == 100) begin
            timer_DONE <= 1'b1;
        end else begin
            tcnt <= tcnt + 1;
        end
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tcnt2 <= 0; timer_DONE2 <= 1'b0;
        end else if (!timer_EN2) begin
            tcnt2 <= 0; timer_DONE2 <= 1'b0;
        end else if (tcnt2 == 100) begin
            timer_DONE2 <= 1'b1;
        end else begin
            tcnt2 <= tcnt2 + 1;
        end
    end

    // Reference model: a qualification is pending whenever the delayed input differs from the committed level.
    logic [NS-1:0] m_hist;
    logic          m_level, m_pending, m_rise, m_fall;
    int            m_glitch;

    always @(posedge CLK or negedge RST) begin : model
        logic s;
        if (!RST) begin
            m_hist <= '0; m_level <= 1'b0; m_pending <= 1'b0;
            m_rise <= 1'b0; m_fall <= 1'b0; m_glitch <= 0;
        end else begin
            s = m_hist[NS-1];
            m_hist <= {m_hist[NS-2:0], noisy_in};
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (!m_pending) begin
                m_pending <= (s != m_level);
            end else if (s == m_level) begin
                m_pending <= 1'b0;
                m_glitch  <= (m_glitch < 255) ? m_glitch + 1 : m_glitch;
            end else if (timer_DONE) begin
                m_pending <= 1'b0;
                m_level   <= s;
                m_rise    <= s;
                m_fall    <= !s;
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model, plus pulse/enable bookkeeping.
    always @(negedge CLK) begin
        tests++;
        if (timer_EN !== m_pending || debounced_out !== m_level || rise_pulse !== m_rise ||
            fall_pulse !== m_fall || glitch_cnt !== 8'(m_glitch)) begin
            fails++;
            $display("FAIL cycle_model t=%0t: en/lvl/rise/fall/glitch got %b%b%b%b/%0d expected %b%b%b%b/%0d",
                     $time, timer_EN, debounced_out, rise_pulse, fall_pulse, glitch_cnt,
                     m_pending, m_level, m_rise, m_fall, m_glitch);
        end
        tests++;
        if (timer_EN2 !== m_pending || debounced_out2 !== m_level || rise_pulse2 !== m_rise ||
            fall_pulse2 !== m_fall) begin
            fails++;
            $display("FAIL cycle_model_w2 t=%0t: en/lvl/rise/fall got %b%b%b%b expected %b%b%b%b",
                     $time, timer_EN2, debounced_out2, rise_pulse2, fall_pulse2,
                     m_pending, m_level, m_rise, m_fall);
        end
        if (rise_pulse) rise_n++;
        if (fall_pulse) fall_n++;
        if (timer_EN && RST) en_seen++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic edge_at;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n, r0, f0, g0;

        // 1: reset state and idle input
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_en", timer_EN, 0);
        chk("reset_level", debounced_out, 0);
        chk("reset_glitch", glitch_cnt, 0);
        @(negedge CLK) RST = 1'b1;
        repeat (500) @(posedge CLK);
        #1;
        chk("t1_en_never", en_seen, 0);
        chk("t1_level", debounced_out, 0);
        chk("t1_glitch", glitch_cnt, 0);

        // 2: clean rise
        edge_at();
        noisy_in = 1'b1;
        n = 0;
        do begin edge_at(); n++; end while (!timer_EN && n < 20);
        chk("t2_en_latency", n, 3);
        do begin edge_at(); n++; end while (!rise_pulse && n < 200);
        chk("t2_rise_at", n, 105);
        chk("t2_level", debounced_out, 1);
        edge_at();
        chk("t2_pulse_1cyc", rise_pulse, 0);
        chk("t2_en_dropped", timer_EN, 0);
        repeat (200) @(posedge CLK);

        // clean fall back to low
        #1 f0 = fall_n;
        noisy_in = 1'b0;
        repeat (130) @(posedge CLK);
        #1;
        chk("fall_count", fall_n - f0, 1);
        chk("fall_level", debounced_out, 0);

        // 3: bounce, five edges 20 cycles apart, ending high
        r0 = rise_n; f0 = fall_n; g0 = glitch_cnt;
        for (int i = 0; i < 5; i++) begin
            noisy_in = (i % 2 == 0);
            repeat (20) @(posedge CLK);
            #1;
        end
        repeat (150) @(posedge CLK);
        #1;
        chk("t3_single_rise", rise_n - r0, 1);
        chk("t3_no_fall", fall_n - f0, 0);
        chk("t3_glitches", glitch_cnt - g0, 2);
        chk("t3_level", debounced_out, 1);
        noisy_in = 1'b0;
        repeat (130) @(posedge CLK);
        #1;
        chk("t3_back_low", debounced_out, 0);

        // 4: input reverts in the very cycle DONE is first seen
        g0 = glitch_cnt; r0 = rise_n;
        noisy_in = 1'b1;
        repeat (102) @(posedge CLK);
        #1 noisy_in = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("t4_done_high", timer_DONE, 1);
        chk("t4_still_check", timer_EN, 1);
        edge_at();
        chk("t4_en_dropped", timer_EN, 0);
        chk("t4_glitch_inc", glitch_cnt - g0, 1);
        repeat (5) @(posedge CLK);
        #1;
        chk("t4_no_rise", rise_n - r0, 0);
        chk("t4_level", debounced_out, 0);

        // 5: five short glitches
        for (int i = 0; i < 5; i++) begin
            noisy_in = 1'b1;
            repeat (10) @(posedge CLK);
            #1 noisy_in = 1'b0;
            repeat (10) @(posedge CLK);
            #1;
        end
        repeat (10) @(posedge CLK);
        #1;
        chk("t5_glitch_total", glitch_cnt, 8);
        chk("t5_glitch_sat_w2", glitch_cnt2, 3);

        // 6: reset in the middle of a qualification
        noisy_in = 1'b1;
        repeat (3) @(posedge CLK);
        repeat (50) @(posedge CLK);
        #1;
        chk("t6_mid_check", timer_EN, 1);
        RST = 1'b0;
        #1;
        chk("t6_en_cleared", timer_EN, 0);
        chk("t6_level_cleared", debounced_out, 0);
        chk("t6_glitch_cleared", glitch_cnt, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST = 1'b1;
        n = 0;
        do begin edge_at(); n++; end while (!rise_pulse && n < 200);
        chk("t6_requalify", n, 105);
        chk("t6_level", debounced_out, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
